pattern_response_misr: RTL and testbench

//  Response-side end of the pattern-merge benchmark harness: consumes the output word of a

---
 rtl/pattern_response_misr_pkg.sv | 16 +
 rtl/pattern_response_misr_misr_core.sv | 20 ++
 rtl/pattern_response_misr.sv | 109 ++++++++++
 tb/tb_pattern_response_misr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_response_misr_pkg.sv
// Shared types and default constants for the response-side MISR compactor.
// The FSM state enum lives here so that the top and any debug tooling agree on the encoding.
package pattern_response_misr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // x^16 + x^5 + x^3 + x^2 + 1, bit i feeds sig[i]
    localparam logic [15:0] DEFAULT_POLY = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

endpackage

// File: rtl/pattern_response_misr_misr_core.sv
// Combinational MISR step: shift left, fold the MSB back through the tap mask,
// then XOR in the response word (zero-extended into the low bits).
module misr_core #(
    parameter int                 RESP_W = 12,
    parameter int                 SIG_W  = 16,
    parameter logic [SIG_W-1:0]   POLY   = SIG_W'(16'h002D)
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig_next
);

    logic [SIG_W-1:0] feedback;

    always_comb begin
        feedback = sig[SIG_W-1] ? POLY : '0;
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ SIG_W'(data);
    end

endmodule

// File: rtl/pattern_response_misr.sv
// Response compactor: accepts one CUT output word per beat into a MISR, counts beats,
// and compares the final signature with a golden value latched at start.
module pattern_response_misr
    import pattern_response_misr_pkg::*;
#(
    parameter int               RESP_W = 12,
    parameter int               SIG_W  = 16,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEFAULT_SEED)
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [SIG_W-1:0]  expected_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp_data,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  count
);

    state_e            state_q, state_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [SIG_W-1:0]  exp_q, exp_d;
    logic              pass_q, pass_d;
    logic [SIG_W-1:0]  sig_next;

    misr_core #(
        .RESP_W (RESP_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY)
    ) u_misr_core (
        .sig      (sig_q),
        .data     (resp_data),
        .sig_next (sig_next)
    );

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        num_d   = num_q;
        exp_d   = exp_q;
        pass_d  = pass_q;

        case (state_q)
            // A restart from DONE behaves exactly like a start from IDLE.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    num_d   = num_patterns;
                    exp_d   = expected_sig;
                    pass_d  = 1'b0;
                    state_d = (num_patterns == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                if (resp_valid) begin
                    sig_d   = sig_next;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == num_q - CNT_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                pass_d  = (sig_q == exp_q);
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            count_q <= '0;
            num_q   <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            num_q   <= num_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        resp_ready = (state_q == ST_RUN);
        busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
        done       = (state_q == ST_DONE);
        pass       = pass_q;
        signature  = sig_q;
        count      = count_q;
    end

endmodule

// File: tb/tb_pattern_response_misr.sv
// Randomised bench for pattern_response_misr: two instances (default seed and seed 0x8000)
// share stimulus and are compared against a GF(2) polynomial-division reference model.
module tb_pattern_response_misr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_patterns = '0;
    logic [15:0] expected_sig = '0;
    logic        resp_valid = 1'b0;
    logic [11:0] resp_data = '0;

    logic        rr    [2];
    logic        busy  [2];
    logic        done  [2];
    logic        pass  [2];
    logic [15:0] sig   [2];
    logic [15:0] cnt   [2];

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] m_seed [2];
    logic [15:0] m_sig  [2];
    logic        m_pass [2];
    logic [15:0] m_cnt;
    logic        m_busy, m_done, m_rr;

    logic [11:0] data_q [$];
    int          gap_q  [$];

    always #5 clk = ~clk;

    pattern_response_misr u_dut0 (
        .blif_clk_net (clk), .blif_reset_net (rst_n), .start (start),
        .num_patterns (num_patterns), .expected_sig (expected_sig),
        .resp_valid (resp_valid), .resp_data (resp_data), .resp_ready (rr[0]),
        .busy (busy[0]), .done (done[0]), .pass (pass[0]),
        .signature (sig[0]), .count (cnt[0])
    );

    pattern_response_misr #(.SEED(16'h8000)) u_dut1 (
        .blif_clk_net (clk), .blif_reset_net (rst_n), .start (start),
        .num_patterns (num_patterns), .expected_sig (expected_sig),
        .resp_valid (resp_valid), .resp_data (resp_data), .resp_ready (rr[1]),
        .busy (busy[1]), .done (done[1]), .pass (pass[1]),
        .signature (sig[1]), .count (cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Signature as a polynomial: multiply by x, reduce modulo P(x), add the data word.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [11:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h1002D;
        return t[15:0] ^ {4'h0, d};
    endfunction

    task automatic model_reset();
        m_sig  = '{16'h0, 16'h0};
        m_pass = '{1'b0, 1'b0};
        m_cnt  = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_rr   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_sig%0d", tag, i),   sig[i],  m_sig[i]);
            check($sformatf("%s_cnt%0d", tag, i),   cnt[i],  m_cnt);
            check($sformatf("%s_busy%0d", tag, i),  busy[i], m_busy);
            check($sformatf("%s_done%0d", tag, i),  done[i], m_done);
            check($sformatf("%s_rdy%0d", tag, i),   rr[i],   m_rr);
            check($sformatf("%s_pass%0d", tag, i),  pass[i], m_pass[i]);
        end
    endtask

    // Runs one job; abort_after >= 0 returns after that many beats (run left open).
    task automatic run(input int num, input logic [15:0] exp, input int abort_after);
        int          gap;
        logic [11:0] d;
        start = 1'b1; num_patterns = 16'(num); expected_sig = exp;
        @(posedge clk); #1;
        start = 1'b0;
        m_sig  = m_seed;
        m_cnt  = '0;
        m_done = 1'b0;
        m_pass = '{1'b0, 1'b0};
        m_busy = 1'b1;
        m_rr   = (num != 0);
        check_all("start");
        for (int b = 0; b < num; b++) begin
            if (b == abort_after) return;
            gap = (gap_q.size() > 0) ? gap_q.pop_front() : int'($urandom_range(0, 2));
            repeat (gap) begin
                // A start pulse in the middle of a run must be ignored.
                resp_valid = 1'b0; resp_data = 12'($urandom);
                start = 1'b1; num_patterns = 16'($urandom); expected_sig = 16'($urandom);
                @(posedge clk); #1;
                start = 1'b0;
                check_all("gap");
            end
            d = (data_q.size() > 0) ? data_q.pop_front() : 12'($urandom);
            resp_valid = 1'b1; resp_data = d;
            @(posedge clk); #1;
            resp_valid = 1'b0;
            for (int i = 0; i < 2; i++) m_sig[i] = ref_step(m_sig[i], d);
            m_cnt++;
            if (b == num - 1) m_rr = 1'b0;
            check_all("beat");
        end
        @(posedge clk); #1;
        m_busy = 1'b0;
        m_done = 1'b1;
        for (int i = 0; i < 2; i++) m_pass[i] = (m_sig[i] == exp);
        check_all("done");
        // Words offered after completion must not be absorbed.
        resp_valid = 1'b1; resp_data = 12'($urandom);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        check_all("hold");
    endtask

    initial begin
        logic [11:0] tmp [$];
        logic [15:0] e;
        int          n;
        m_seed = '{16'h0000, 16'h8000};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("idle");

        data_q = '{12'hABC}; gap_q = '{0};
        run(1, 16'h0ABC, -1);
        check("t1_sig", sig[0], 16'h0ABC);
        check("t1_pass", pass[0], 1'b1);

        data_q = '{12'h001, 12'h000}; gap_q = '{0, 0};
        run(2, 16'h0002, -1);
        check("t2_sig", sig[0], 16'h0002);
        check("t2_pass", pass[0], 1'b1);
        data_q = '{12'h001, 12'h000}; gap_q = '{1, 0};
        run(2, 16'h0003, -1);
        check("t2_fail", pass[0], 1'b0);

        data_q = '{12'h000}; gap_q = '{0};
        run(1, 16'h002D, -1);
        check("t3_sig", sig[1], 16'h002D);
        check("t3_pass", pass[1], 1'b1);

        gap_q = '{0, 2, 5};
        run(3, 16'h1234, -1);
        check("t4_cnt", cnt[0], 16'd3);

        run(0, 16'h0000, -1);
        check("t5_sig1", sig[1], 16'h8000);
        check("t5_pass0", pass[0], 1'b1);
        check("t5_pass1", pass[1], 1'b0);

        gap_q = '{0, 1};
        run(4, 16'h5555, 2);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all("postrst");
        run(4, 16'h0F0F, -1);

        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(1, 6));
            tmp.delete();
            for (int k = 0; k < n; k++) tmp.push_back(12'($urandom));
            e = m_seed[0];
            foreach (tmp[k]) e = ref_step(e, tmp[k]);
            if ($urandom_range(0, 1) == 0) e = 16'($urandom);
            data_q = tmp;
            run(n, e, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
